nes_line_doubler: RTL
=====================

// Module: nes_line_doubler
// PURPOSE
//  Downstream of the NES palette/sync stage: takes one 4-clk-rate pixel stream (RGB888 + syncs/blanks)
//  and emits each input line twice at 2x pixel rate (240p -> 480p, 31 kHz) for analog/VGA paths.
//  Ping-pong line buffers; output phase-locked to input ce. Drop-in non-hq2x scandoubler path.
// PARAMETERS
//  DEPTH    512  words per line buffer (input pixels/line max; NES line = 341)
//  HS_START 280  output pixel index where hs_out asserts
//  HS_WIDTH 12   hs_out pulse length, output pixels
// PORTS
//  clk          in   1   system clock
//  reset        in   1   synchronous, active-high
//  ce_pix       in   1   input pixel enable, 1 of every 4 clk
//  r_in/g_in/b_in in 8 each  input colour, valid on ce_pix
//  hblank_in    in   1   input horizontal blank
//  vblank_in    in   1   input vertical blank
//  hs_in        in   1   input hsync, active-high
//  vs_in        in   1   input vsync, active-high
//  ce_pix_out   out  1   output pixel enable, 1 of every 2 clk
//  r_out/g_out/b_out out 8 each  output colour, 0 when de_out=0
//  hs_out       out  1   output hsync, active-high
//  vs_out       out  1   output vsync, active-high
//  de_out       out  1   output data enable = ~hblank & ~vblank of stored pixel
// BEHAVIOUR
//  Reset: all outputs 0; counters 0; wbank=0; primed=0; line_len=0. Buffer contents don't-care.
//  ce_pix_out: high on every ce_pix cycle and exactly 2 clk after it (ce_d2). Never two in a row.
//  Write side (on ce_pix): hs_in rising edge (vs ce_pix-sampled prev) -> line_len<=min(hcnt,DEPTH),
//   hcnt<=0, wbank<=~wbank, primed<=1, latch vblank_in into line_vb, vs_in into line_vs;
//   else write {rgb,hblank_in} to buf[wbank][hcnt] if hcnt<DEPTH, hcnt<=hcnt+1 (sat at 1023, 10b).
//   Pixels with hcnt>=DEPTH dropped silently.
//  Read side (on ce_pix_out): reads buf[~wbank][ocnt]; ocnt 0..line_len-1 then wraps to 0, oline toggles.
//   Input hs rising edge forces ocnt<=0, oline<=0 on same cycle (overrides wrap; restart wins).
//   After oline=1 line completes, ocnt holds at line_len-1, de_out=0 until next hs edge (short line).
//   2*line_len output pixels == line_len input pixels, so normal lines need no hold.
//  Read latency: RAM registered read; outputs update on ce_pix_out 2 slots after address -> total
//   latency 1 input line + 2 output pixels. Pipeline hblank/ocnt-derived signals to match.
//  de_out = primed & ~stored_hblank & ~line_vb; rgb_out = de_out ? stored : 0.
//  hs_out = (ocnt in [HS_START, HS_START+HS_WIDTH)), pipelined to align; both output lines of pair.
//  vs_out = line_vs of the line being read, updated at ocnt==0 of oline=0 only.
//  line_len<=HS_START (e.g. 0 after reset): hs_out stays 0, de_out 0; no X, no lockup.
//  primed=0 (before first hs edge): de_out=0, rgb_out=0, hs_out/vs_out=0.
//  Reset mid-line: next clk all state as reset; first hs edge after reset primes.
// STRUCTURE
//  Package nes_video_pkg: typedef rgb_t {r,g,b 8b}; typedef lb_word_t {rgb_t, hblank}; DEPTH default.
//  Sub-module nes_line_ram: simple dual-port (1W/1R), DEPTH x 25b, registered read, one per bank
//   (or one 2*DEPTH with bank as MSB). Top holds counters, sync gen, ce generation.
// TESTING
//  1 Reset held 10 clk, ce_pix every 4 -> all outputs 0; ce_pix_out high at ce and ce+2 only.
//  2 Lines of 341 px, 256 active, hs_in 277..301, pixel=hcnt -> line N+1 outputs line N twice,
//    682 ce_pix_out per input line, de_out 256 px each half, data matches incl. 2-pixel latency.
//  3 hs_out: 12-px pulse at ocnt 280 in both halves; vs_in high lines 242-244 -> vs_out high on
//    exactly 6 output lines, delayed one input line.
//  4 Short line (hs after 200 px, prior len 341) -> second half truncated, ocnt restarts at 0,
//    no stale pixels past restart; following 341-px line back to normal.
//  5 Overlong line 600 px (DEPTH 512) -> line_len=512, pixels 512+ dropped, no address wrap.
//  6 Reset asserted at ocnt=100 of oline=1 -> next clk outputs 0, de_out stays 0 until first
//    hs edge post-reset, then normal doubling resumes one line later.

Source files
------------

// File: rtl/nes_video_pkg.sv
// Shared video types for the NES output path: pixel colour, line-buffer word, read sequencer states.
package nes_video_pkg;

  localparam int LB_DEPTH = 512;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct packed {
    rgb_t rgb;
    logic hblank;
  } lb_word_t;

  typedef enum logic [1:0] {
    RD_FIRST  = 2'd0,
    RD_SECOND = 2'd1,
    RD_HOLD   = 2'd2
  } rd_state_t;

endpackage

// File: rtl/nes_line_ram.sv
// Simple dual-port line buffer: one write port, one registered read port (1 clk read latency when rd_en).
module nes_line_ram
  import nes_video_pkg::*;
#(
  parameter int WORDS = 1024,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  lb_word_t      wr_dat,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output lb_word_t      rd_dat
);

  lb_word_t mem [WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
    if (rd_en) rd_dat <= mem[rd_addr];
  end

endmodule

// File: rtl/nes_line_doubler.sv
// Scandoubler: each input line replayed twice at 2x pixel rate from ping-pong buffers.
// Output trails input by one line plus two output pixels; no backpressure, strobe driven.
module nes_line_doubler
  import nes_video_pkg::*;
#(
  parameter int DEPTH    = LB_DEPTH,
  parameter int HS_START = 280,
  parameter int HS_WIDTH = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce_pix,
  input  logic [7:0] r_in,
  input  logic [7:0] g_in,
  input  logic [7:0] b_in,
  input  logic       hblank_in,
  input  logic       vblank_in,
  input  logic       hs_in,
  input  logic       vs_in,
  output logic       ce_pix_out,
  output logic [7:0] r_out,
  output logic [7:0] g_out,
  output logic [7:0] b_out,
  output logic       hs_out,
  output logic       vs_out,
  output logic       de_out
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [9:0]  DEPTH_W  = 10'(DEPTH);
  localparam logic [9:0]  HCNT_MAX = 10'h3ff;
  localparam logic [9:0]  HS_LO    = 10'(HS_START);
  localparam logic [9:0]  HS_HI    = 10'(HS_START + HS_WIDTH);

  logic       ce_d1, ce_d2;
  logic       hs_prev, hs_edge, wbank, primed, line_vb, line_vs;
  logic [9:0] hcnt, line_len, ocnt;
  rd_state_t  state, state_nxt;
  logic       oline, active, last;
  logic       a_vld, a_hs, a_vs;
  logic       s1_vld, s1_hs, s1_vs, de_nxt;
  logic       wr_en;
  logic [AW:0] wr_addr, rd_addr;
  lb_word_t   wr_dat, rd_dat;

  // Strobe delay line is deliberately not reset so the output cadence survives a reset.
  always_ff @(posedge clk) begin
    ce_d1 <= ce_pix;
    ce_d2 <= ce_d1;
  end
  assign ce_pix_out = ce_pix | ce_d2;

  assign hs_edge = ce_pix & hs_in & ~hs_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_prev  <= 1'b0;
      hcnt     <= '0;
      line_len <= '0;
      wbank    <= 1'b0;
      primed   <= 1'b0;
      line_vb  <= 1'b0;
      line_vs  <= 1'b0;
    end else if (ce_pix) begin
      hs_prev <= hs_in;
      if (hs_edge) begin
        line_len <= (hcnt > DEPTH_W) ? DEPTH_W : hcnt;
        hcnt     <= '0;
        wbank    <= ~wbank;
        primed   <= 1'b1;
        line_vb  <= vblank_in;
        line_vs  <= vs_in;
      end else if (hcnt != HCNT_MAX) begin
        hcnt <= hcnt + 10'd1;
      end
    end
  end

  assign wr_en   = ce_pix & ~reset & ~hs_edge & (hcnt < DEPTH_W);
  assign wr_addr = {wbank, hcnt[AW-1:0]};
  assign wr_dat  = '{rgb: '{r: r_in, g: g_in, b: b_in}, hblank: hblank_in};
  assign rd_addr = {~wbank, ocnt[AW-1:0]};

  nes_line_ram #(.WORDS(2 * DEPTH)) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_dat  (wr_dat),
    .rd_en   (ce_pix_out),
    .rd_addr (rd_addr),
    .rd_dat  (rd_dat)
  );

  // Widened compare so line_len==0 counts as "last" instead of underflowing.
  assign last = ({1'b0, ocnt} + 11'd1) >= {1'b0, line_len};

  always_ff @(posedge clk) begin
    if (reset) state <= RD_FIRST;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (hs_edge) begin
      state_nxt = RD_FIRST;
    end else if (ce_pix_out && last) begin
      case (state)
        RD_FIRST:  state_nxt = RD_SECOND;
        RD_SECOND: state_nxt = RD_HOLD;
        default:   state_nxt = RD_HOLD;
      endcase
    end
  end

  always_comb begin
    oline  = 1'b0;
    active = 1'b1;
    case (state)
      RD_FIRST:  ;
      RD_SECOND: oline = 1'b1;
      default: begin
        oline  = 1'b1;
        active = 1'b0;
      end
    endcase
  end

  assign a_vld  = primed & active & (ocnt < line_len) & ~line_vb;
  assign a_hs   = primed & active & (ocnt >= HS_LO) & (ocnt < HS_HI);
  assign a_vs   = (~oline && ocnt == 10'd0) ? line_vs : s1_vs;
  assign de_nxt = s1_vld & ~rd_dat.hblank;

  // s1_* travel alongside the registered RAM read; outputs land one slot later.
  always_ff @(posedge clk) begin
    if (reset) begin
      ocnt   <= '0;
      s1_vld <= 1'b0;
      s1_hs  <= 1'b0;
      s1_vs  <= 1'b0;
      de_out <= 1'b0;
      r_out  <= '0;
      g_out  <= '0;
      b_out  <= '0;
      hs_out <= 1'b0;
      vs_out <= 1'b0;
    end else begin
      if (hs_edge) begin
        ocnt <= '0;
      end else if (ce_pix_out && active) begin
        if (!last)      ocnt <= ocnt + 10'd1;
        else if (!oline) ocnt <= '0;
      end
      if (ce_pix_out) begin
        s1_vld <= a_vld;
        s1_hs  <= a_hs;
        s1_vs  <= a_vs;
        de_out <= de_nxt;
        r_out  <= de_nxt ? rd_dat.rgb.r : 8'd0;
        g_out  <= de_nxt ? rd_dat.rgb.g : 8'd0;
        b_out  <= de_nxt ? rd_dat.rgb.b : 8'd0;
        hs_out <= s1_hs;
        vs_out <= s1_vs;
      end
    end
  end

endmodule
